// File: rtl/crc8_stream_ctrl.sv
// crc8_stream_ctrl: byte-stream CRC-8 sequencer around a table ROM.
// Each accepted byte is folded through crc_table (addr = crc ^ byte) and the
// result is written back one cycle later, giving one byte per two cycles.
// The finished CRC is offered on a valid/ready handshake.
// Optional feature: define CRC8_STREAM_ABORT_EN to add the abort_i input,
// which discards the current frame without needing a reset.

// crc_table: 256x8 CRC-8 lookup ROM with a one-cycle registered read.
module crc_table #(
    parameter logic [7:0] POLYNOMIAL = 8'h07
) (
    input  logic       i_clk,
    input  logic [7:0] i_addr,
    output logic [7:0] o_data
);

    // Table entry is the byte shifted through the LFSR eight times
    function automatic logic [7:0] tableEntry(input logic [7:0] idx);
        logic [7:0] c;
        c = idx;
        for (int b = 0; b < 8; b++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ POLYNOMIAL;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    logic [7:0] r_data;

    // Registered read every edge; contents are constant so no reset is needed
    always_ff @(posedge i_clk) begin
        r_data <= tableEntry(i_addr);
    end

    assign o_data = r_data;

endmodule

module crc8_stream_ctrl #(
    parameter logic [7:0] POLYNOMIAL = 8'h07,
    parameter logic [7:0] INIT       = 8'h00,
    parameter logic [7:0] XOR_OUT    = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    input  logic       last_i,
    output logic       ready_o,
    output logic [7:0] crc_o,
    output logic       crc_valid_o,
    input  logic       crc_ready_i,
`ifdef CRC8_STREAM_ABORT_EN
    input  logic       abort_i,
`endif
    output logic       busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPD,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [7:0] r_crc;
    logic       r_last;
    logic       r_inFrame;
    logic       r_crcValid;

    logic [7:0] w_romAddr;
    logic [7:0] w_romData;
    logic       w_abort;

`ifdef CRC8_STREAM_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    // The ROM looks up every cycle; its output only matters in S_UPD
    assign w_romAddr = r_crc ^ data_i;

    crc_table #(
        .POLYNOMIAL(POLYNOMIAL)
    ) u_table (
        .i_clk (clk_i),
        .i_addr(w_romAddr),
        .o_data(w_romData)
    );

    // Sequencer: accept a byte, fold it in, and hold the CRC after the last byte
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_crc      <= INIT;
            r_last     <= 1'b0;
            r_inFrame  <= 1'b0;
            r_crcValid <= 1'b0;
        end else if (w_abort) begin
            r_state    <= S_IDLE;
            r_crc      <= INIT;
            r_inFrame  <= 1'b0;
            r_crcValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_last    <= last_i;
                        r_inFrame <= 1'b1;
                        r_state   <= S_UPD;
                    end
                end
                S_UPD: begin
                    r_crc <= w_romData;
                    if (r_last) begin
                        r_state    <= S_DONE;
                        r_crcValid <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (crc_ready_i) begin
                        r_crc      <= INIT;
                        r_inFrame  <= 1'b0;
                        r_crcValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Reset parks the FSM in S_IDLE, so ready is masked while reset is held
    assign ready_o     = (r_state == S_IDLE) && rst_ni;
    assign crc_o       = r_crc ^ XOR_OUT;
    assign crc_valid_o = r_crcValid;
    assign busy_o      = r_inFrame;

endmodule
